// File: rtl/isa24_pkg.sv
// Shared definitions for the 24-bit instruction format: opcodes, field positions,
// loader error codes and loader FSM states.
package isa24_pkg;

   localparam logic [3:0] OP_HALT  = 4'd0;
   localparam logic [3:0] OP_ADD   = 4'd1;
   localparam logic [3:0] OP_MUL   = 4'd3;
   localparam logic [3:0] OP_LI    = 4'd4;
   localparam logic [3:0] OP_LOAD  = 4'd5;
   localparam logic [3:0] OP_STORE = 4'd6;
   localparam logic [3:0] OP_BEQ   = 4'd7;
   localparam logic [3:0] OP_JMP   = 4'd8;

   localparam int OP_MSB    = 23;
   localparam int OP_LSB    = 20;
   localparam int RS1_MSB   = 19;
   localparam int RS1_LSB   = 14;
   localparam int RS2_MSB   = 13;
   localparam int RS2_LSB   = 8;
   localparam int RD_MSB    = 7;
   localparam int RD_LSB    = 2;
   localparam int IMM8_MSB  = 7;
   localparam int IMM8_LSB  = 0;
   localparam int OFF20_MSB = 19;
   localparam int OFF20_LSB = 0;

   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_BAD_OP    = 2'd1;
   localparam logic [1:0] ERR_IMM_RANGE = 2'd2;
   localparam logic [1:0] ERR_OVERFLOW  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   // True when every bit from msb upward matches the sign bit, i.e. the value
   // survives truncation to an (msb+1)-bit signed field.
   function automatic logic imm_fits(input logic [23:0] imm, input int msb);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 24; i++) begin
         if (i >= msb && imm[i] != imm[23]) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/instr_encode24.sv
// Combinational packer from symbolic instruction fields to the 24-bit word,
// flagging unknown opcodes and immediates that do not fit their field.
module instr_encode24
   import isa24_pkg::*;
(
   input  logic [3:0]  opcode,
   input  logic [5:0]  rs1,
   input  logic [5:0]  rs2,
   input  logic [5:0]  rd,
   input  logic [23:0] imm,
   output logic [23:0] word,
   output logic        bad_op,
   output logic        imm_range
);

   always_comb begin
      word      = '0;
      bad_op    = 1'b0;
      imm_range = 1'b0;
      case (opcode)
         OP_HALT: word = '0;
         OP_ADD, OP_MUL: begin
            word[OP_MSB:OP_LSB]   = opcode;
            word[RS1_MSB:RS1_LSB] = rs1;
            word[RS2_MSB:RS2_LSB] = rs2;
            word[RD_MSB:RD_LSB]   = rd;
         end
         OP_LI, OP_LOAD, OP_STORE, OP_BEQ: begin
            word[OP_MSB:OP_LSB]     = opcode;
            word[RS1_MSB:RS1_LSB]   = rs1;
            word[RS2_MSB:RS2_LSB]   = rs2;
            word[IMM8_MSB:IMM8_LSB] = imm[7:0];
            imm_range               = !imm_fits(imm, 7);
         end
         OP_JMP: begin
            word[OP_MSB:OP_LSB]       = opcode;
            word[OFF20_MSB:OFF20_LSB] = imm[19:0];
            imm_range                 = !imm_fits(imm, 19);
         end
         default: bad_op = 1'b1;
      endcase
   end

endmodule

// File: rtl/program_loader24.sv
// Streams symbolic instructions in, encodes them and writes the words to
// consecutive instruction-memory addresses starting at a latched base address.
module program_loader24
   import isa24_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_opcode,
   input  logic [5:0]        in_rs1,
   input  logic [5:0]        in_rs2,
   input  logic [5:0]        in_rd,
   input  logic [23:0]       in_imm,
   input  logic              in_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [23:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   count
);

   state_t            state, state_next;
   logic [ADDR_W-1:0] ptr;
   logic [23:0]       enc_word;
   logic              enc_bad_op, enc_imm_range;
   logic              enc_fail, accept, load, at_end;

   instr_encode24 u_encode (
      .opcode    (in_opcode),
      .rs1       (in_rs1),
      .rs2       (in_rs2),
      .rd        (in_rd),
      .imm       (in_imm),
      .word      (enc_word),
      .bad_op    (enc_bad_op),
      .imm_range (enc_imm_range)
   );

   assign enc_fail = enc_bad_op | enc_imm_range;
   assign accept   = in_valid && in_ready;
   assign load     = start && (state == ST_IDLE || state == ST_ERR);
   assign at_end   = (ptr == ADDR_W'(DEPTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start) state_next = ST_RUN;
         ST_RUN: begin
            if (accept) begin
               if (enc_fail)     state_next = ST_ERR;
               else if (in_last) state_next = ST_DONE;
               else if (at_end)  state_next = ST_ERR;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         ST_ERR:  if (start) state_next = ST_RUN;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == ST_RUN);
      busy     = (state != ST_IDLE);
      done     = (state == ST_DONE);
   end

   // Writes are registered one cycle behind the handshake; pointer and count
   // advance at the handshake so they are current when the write is visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         count     <= '0;
         err       <= 1'b0;
         err_code  <= ERR_NONE;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= 1'b0;
         if (load) begin
            ptr      <= base_addr;
            count    <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
         end else if (accept) begin
            if (enc_fail) begin
               err      <= 1'b1;
               err_code <= enc_bad_op ? ERR_BAD_OP : ERR_IMM_RANGE;
            end else begin
               mem_we    <= 1'b1;
               mem_addr  <= ptr;
               mem_wdata <= enc_word;
               ptr       <= ptr + ADDR_W'(1);
               count     <= count + (ADDR_W + 1)'(1);
               if (!in_last && at_end) begin
                  err      <= 1'b1;
                  err_code <= ERR_OVERFLOW;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_program_loader24.sv
// Scoreboard bench for program_loader24: stimulus pushes expected writes, a
// negedge monitor pops and compares every memory write it observes.
module tb_program_loader24;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  base_addr;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_opcode;
   logic [5:0]  in_rs1, in_rs2, in_rd;
   logic [23:0] in_imm;
   logic        in_last;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [23:0] mem_wdata;
   logic        busy, done, err;
   logic [1:0]  err_code;
   logic [8:0]  count;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [7:0]  addr;
      logic [23:0] data;
      logic [8:0]  cnt;
      logic        last;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   logic [7:0] exp_ptr;
   logic [8:0] exp_count;

   program_loader24 #(.ADDR_W(8), .DEPTH(256)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_opcode (in_opcode),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_rd     (in_rd),
      .in_imm    (in_imm),
      .in_last   (in_last),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_code  (err_code),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every observed write must match the oldest expected one.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (mem_we) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", mem_addr, mem_wdata);
            end else begin
               mon_e = sb.pop_front();
               check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
               check("wr_data", 32'(mem_wdata), 32'(mon_e.data));
               check("wr_count", 32'(count), 32'(mon_e.cnt));
               check("wr_done", 32'(done), 32'(mon_e.last));
            end
         end else if (done) begin
            check("done_without_write", 32'(done), 32'd0);
         end
      end
   end

   task automatic begin_session(input logic [7:0] base);
      start     = 1'b1;
      base_addr = base;
      exp_ptr   = base;
      exp_count = '0;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [3:0] op, input logic [5:0] r1, input logic [5:0] r2,
                       input logic [5:0] rd, input logic [23:0] imm, input logic last,
                       input logic wr, input logic [23:0] word);
      in_opcode = op;
      in_rs1    = r1;
      in_rs2    = r2;
      in_rd     = rd;
      in_imm    = imm;
      in_last   = last;
      in_valid  = 1'b1;
      check("in_ready_before_send", 32'(in_ready), 32'd1);
      if (wr) begin
         exp_count = exp_count + 9'd1;
         sb.push_back('{addr: exp_ptr, data: word, cnt: exp_count, last: last});
         exp_ptr = exp_ptr + 8'd1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
      in_opcode = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0; in_last = 1'b0;
      exp_ptr = '0; exp_count = '0;
      idle(3);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_ready", 32'(in_ready), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      check("reset_count", 32'(count), 32'd0);
      check("reset_we", 32'(mem_we), 32'd0);
      rst = 1'b0;
      idle(1);

      // ADD, then LI / JMP back-to-back ending the session
      begin_session(8'h10);
      check("run_busy", 32'(busy), 32'd1);
      send(4'd1, 6'd1, 6'd2, 6'd3, 24'd0, 1'b0, 1'b1, 24'h10420C);
      idle(1);
      check("count_after_add", 32'(count), 32'd1);
      send(4'd4, 6'd5, 6'd0, 6'd0, 24'hFFFFFF, 1'b0, 1'b1, 24'h4140FF);
      send(4'd8, 6'd0, 6'd0, 6'd0, 24'hFFFFFE, 1'b1, 1'b1, 24'h8FFFFE);
      check("count_at_done", 32'(count), 32'd3);
      idle(1);
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_after_done", 32'(busy), 32'd0);

      // BEQ immediate out of range, then restart
      begin_session(8'h20);
      send(4'd7, 6'd1, 6'd2, 6'd0, 24'd200, 1'b0, 1'b0, 24'h0);
      check("beq_err", 32'(err), 32'd1);
      check("beq_code", 32'(err_code), 32'd2);
      check("beq_ready", 32'(in_ready), 32'd0);
      idle(2);
      check("err_sticky", 32'(err_code), 32'd2);
      begin_session(8'h20);
      check("restart_err", 32'(err), 32'd0);
      check("restart_ready", 32'(in_ready), 32'd1);

      // bad opcode, then JMP offset out of range
      send(4'd2, 6'd0, 6'd0, 6'd0, 24'd0, 1'b0, 1'b0, 24'h0);
      check("badop_code", 32'(err_code), 32'd1);
      begin_session(8'h30);
      send(4'd8, 6'd0, 6'd0, 6'd0, 24'h080000, 1'b1, 1'b0, 24'h0);
      check("jmp_range_code", 32'(err_code), 32'd2);
      check("jmp_range_idle_not", 32'(busy), 32'd1);

      // write pointer reaching the top of memory
      begin_session(8'd254);
      send(4'd1, 6'd1, 6'd2, 6'd3, 24'd0, 1'b0, 1'b1, 24'h10420C);
      send(4'd4, 6'd5, 6'd0, 6'd0, 24'hFFFFFF, 1'b0, 1'b1, 24'h4140FF);
      check("ovf_err", 32'(err), 32'd1);
      check("ovf_code", 32'(err_code), 32'd3);
      check("ovf_count", 32'(count), 32'd2);
      check("ovf_ready", 32'(in_ready), 32'd0);
      idle(1);
      check("ovf_code_held", 32'(err_code), 32'd3);
      begin_session(8'd254);
      send(4'd1, 6'd1, 6'd2, 6'd3, 24'd0, 1'b0, 1'b1, 24'h10420C);
      send(4'd8, 6'd0, 6'd0, 6'd0, 24'hFFFFFE, 1'b1, 1'b1, 24'h8FFFFE);
      check("last_at_top_err", 32'(err), 32'd0);
      check("last_at_top_done", 32'(done), 32'd1);
      idle(1);

      // reset in the middle of a session
      begin_session(8'h40);
      send(4'd1, 6'd1, 6'd2, 6'd3, 24'd0, 1'b0, 1'b1, 24'h10420C);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst_we", 32'(mem_we), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_ready", 32'(in_ready), 32'd0);
      @(negedge clk); #1;
      rst = 1'b0;
      idle(1);
      begin_session(8'h50);
      send(4'd0, 6'd7, 6'd9, 6'd11, 24'h123456, 1'b1, 1'b1, 24'h000000);
      idle(3);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/program_loader24.md
Name: program_loader24

Overview:
Encoder-side counterpart to the 24-bit instruction decoder.
- Accepts symbolic instruction fields over a valid/ready stream.
- Packs each instruction into the 24-bit word format with range checks.
- Writes the words into word-addressed instruction memory at consecutive addresses starting from a base address.
- Used by the testbench/boot path to load programs before the CPU is released from reset.

Parameters:
ADDR_W, 8, instruction-memory word-address width.
DEPTH, 256, number of memory words; DEPTH <= 2**ADDR_W.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-high reset.
start  in  1  begin load session; sampled in IDLE and ERR only.
base_addr  in  ADDR_W  first write address, latched on start.
in_valid  in  1  instruction fields valid.
in_ready  out  1  loader can accept; high only in RUN.
in_opcode  in  4  HALT=0, ADD=1, MUL=3, LI=4, LOAD=5, STORE=6, BEQ=7, JMP=8.
in_rs1  in  6  field [19:14]; carries the LOAD destination and the STORE data register.
in_rs2  in  6  field [13:8]; carries the LOAD/STORE base register.
in_rd  in  6  field [7:2]; R-type only.
in_imm  in  24  signed immediate/offset.
in_last  in  1  final instruction of session.
mem_we  out  1  memory write strobe.
mem_addr  out  ADDR_W  write address.
mem_wdata  out  24  encoded word.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse on successful completion.
err  out  1  sticky error flag.
err_code  out  2  0 none, 1 BAD_OP, 2 IMM_RANGE, 3 OVERFLOW.
count  out  ADDR_W+1  words written this session.

Behaviour:
- Reset: state IDLE; all outputs 0; write pointer 0. Reset mid-session aborts immediately; no further mem_we.
- Encoding:
  - ADD/MUL: {op, rs1, rs2, rd, 2'b00}.
  - LI/LOAD/STORE/BEQ: {op, rs1, rs2, imm[7:0]}. Requires imm[23:7] all equal, else IMM_RANGE.
  - JMP: {op, imm[19:0]}. Requires imm[23:19] all equal, else IMM_RANGE.
  - HALT: 24'h000000; other fields ignored.
  - Opcodes 2 and 9..15: BAD_OP.
- States: IDLE, RUN, DONE, ERR.
- IDLE: on start, latch ptr <= base_addr, clear count, err, err_code; go to RUN.
- RUN:
  - in_ready = 1. A handshake occurs when in_valid && in_ready; one instruction is accepted per cycle, back-to-back allowed.
  - Encode error on handshake: no write, err = 1, err_code set, go to ERR.
  - Otherwise, registered write: mem_we = 1 in the cycle after the handshake, with mem_addr = ptr and mem_wdata = encoded word. ptr increments and count increments with the write.
  - in_last accepted: go to DONE.
  - Not last and ptr == DEPTH-1 at the write: write completes, then err_code = OVERFLOW, go to ERR.
  - in_last takes priority over OVERFLOW on the same word.
  - start is ignored in RUN.
- DONE: done = 1 for exactly one cycle, coincident with the final mem_we; then go to IDLE.
- ERR: in_ready = 0. err and err_code hold until start (restart session, same as from IDLE) or rst.
- mem_we is never asserted outside the cycle following a valid, error-free handshake.
- count saturates nowhere; its maximum value is DEPTH.

Decomposition:
- Package isa24_pkg:
  - opcode localparams;
  - field bit positions (OP 23:20, RS1 19:14, RS2 13:8, RD 7:2, IMM8 7:0, OFF20 19:0);
  - err_code constants;
  - FSM state encoding.
- Sub-module instr_encode24 (combinational): fields in; 24-bit word, bad_op and imm_range flags out. It shares the package with the decoder so round-trip checks are trivial.

Test Plan:
1. base_addr=0x10; ADD rs1=1 rs2=2 rd=3, in_last=0 -> mem_we next cycle, mem_addr=0x10, mem_wdata=24'h10420C, count=1.
2. LI rs1=5 rs2=0 imm=-1, then JMP imm=-2 last, back-to-back -> writes 24'h4140FF at 0x11 and 24'h8FFFFE at 0x12; done pulses with the second write; count=3.
3. BEQ imm=200 -> no write, err=1, err_code=2, in_ready=0; start -> err clears, RUN.
4. in_opcode=2 -> err_code=1, no write; JMP imm=24'h080000 -> err_code=2.
5. base_addr=254, two non-last words -> writes at 254 and 255, then err_code=3, count=2. Repeat with in_last on the second word -> done, err=0.
6. rst pulsed between two accepted words in RUN -> mem_we=0, busy=0, count=0 immediately; HALT last after restart -> writes 24'h000000, done.
